// File: rtl/qkd_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : qkd_bank_writer
// Brief    : Streams QKD samples into a ring of on-chip memory banks. Each
//            bank is filled word by word; a full bank raises its irq level
//            until software acknowledges it as drained. When the next bank
//            is still full, samples are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module qkd_bank_writer #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_writedata,
  output logic [DATA_W/8-1:0]    mem_byteenable,
  output logic [NUM_BANKS-1:0]   mem_clken,
  output logic [NUM_BANKS-1:0]   mem_chipselect,
  output logic [NUM_BANKS-1:0]   mem_write,
  output logic [NUM_BANKS-1:0]   irq,
  input  logic [NUM_BANKS-1:0]   irq_ack,
  output logic [2:0]             cur_bank,
  output logic [15:0]            overflow_count
);

  // Increment constant for the write pointer, sized to the address width.
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        LAST_BANK = 3'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [ADDR_W-1:0]     wr_ptr;
  logic [NUM_BANKS-1:0]  full;

  logic                  accept;
  logic                  last_word;
  logic                  bank_wrap;
  logic [2:0]            bank_next_idx;
  logic [NUM_BANKS-1:0]  cur_sel;
  logic [NUM_BANKS-1:0]  next_sel;
  logic [NUM_BANKS-1:0]  full_acked;
  logic [NUM_BANKS-1:0]  full_next;
  logic                  full_cur;
  logic                  full_next_bank;

  // Handshake: the stream is only accepted while a bank is being filled.
  assign in_ready       = (state == FILL);
  assign accept         = in_valid & in_ready;
  assign last_word      = &wr_ptr;
  assign bank_wrap      = accept & last_word;
  assign bank_next_idx  = (cur_bank == LAST_BANK) ? 3'd0 : cur_bank + 3'd1;

  // Whole-word writes only; the irq level is the full flag itself.
  assign mem_byteenable = '1;
  assign irq            = full;

  // One-hot decode of the current and the following bank index.
  always_comb begin
    cur_sel  = '0;
    next_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cur_sel[i]  = (cur_bank == 3'(i));
      next_sel[i] = (bank_next_idx == 3'(i));
    end
  end

  // Full flags after this cycle's acknowledges; a fill in the same cycle wins.
  always_comb begin
    full_acked     = full & ~irq_ack;
    full_next      = full_acked | (bank_wrap ? cur_sel : '0);
    full_cur       = |(full & cur_sel);
    full_next_bank = |(full_acked & next_sel);
  end

  // Next-state logic: dropping enable always returns to IDLE.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = full_cur ? WAIT_FREE : FILL;
        FILL:      if (bank_wrap && full_next_bank) state_next = WAIT_FREE;
        WAIT_FREE: if (!full_cur) state_next = FILL;
        default:   state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write pointer and bank index; a partial bank is discarded on disable.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr   <= '0;
      cur_bank <= 3'd0;
    end else begin
      if (bank_wrap) begin
        cur_bank <= bank_next_idx;
      end
      if (!enable) begin
        wr_ptr <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  // Per-bank full flags, set on the last word and cleared by acknowledge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      full <= '0;
    end else begin
      full <= full_next;
    end
  end

  // Registered memory port: strobes and data one cycle after acceptance.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mem_clken      <= '0;
      mem_write      <= '0;
      mem_chipselect <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      mem_clken      <= '1;
      mem_write      <= accept ? cur_sel : '0;
      mem_chipselect <= accept ? cur_sel : '0;
      if (accept) begin
        mem_address   <= wr_ptr;
        mem_writedata <= in_data;
      end
    end
  end

  // Dropped-sample counter, saturating so software never sees a wrap.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overflow_count <= 16'd0;
    end else if ((state == WAIT_FREE) && in_valid && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qkd_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qkd_bank_writer
// Brief    : Self-checking bench for qkd_bank_writer (2 banks x 8 words).
//            Directed scenarios followed by randomized traffic, all compared
//            every cycle against a behavioural model of the bank ring.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qkd_bank_writer;

  localparam int NB    = 2;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic            clk_clk     = 1'b0;
  logic            reset_reset = 1'b1;
  logic            enable      = 1'b0;
  logic            in_valid    = 1'b0;
  logic [DW-1:0]   in_data     = '0;
  logic [NB-1:0]   irq_ack     = '0;
  logic            in_ready;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_writedata;
  logic [DW/8-1:0] mem_byteenable;
  logic [NB-1:0]   mem_clken;
  logic [NB-1:0]   mem_chipselect;
  logic [NB-1:0]   mem_write;
  logic [NB-1:0]   irq;
  logic [2:0]      cur_bank;
  logic [15:0]     overflow_count;

  int n_checks = 0;
  int n_fail   = 0;

  qkd_bank_writer #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .irq            (irq),
    .irq_ack        (irq_ack),
    .cur_bank       (cur_bank),
    .overflow_count (overflow_count)
  );

  always #5 clk_clk = ~clk_clk;

  // ---------------- behavioural model of the bank ring ----------------
  typedef enum int {M_IDLE, M_FILL, M_WAIT} mstate_t;
  mstate_t       m_state = M_IDLE;
  int            m_ptr   = 0;
  int            m_bank  = 0;
  int            m_ovf   = 0;
  logic [NB-1:0] m_full  = '0;
  logic [NB-1:0] e_write = '0;
  logic [NB-1:0] e_clken = '0;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_data  = '0;

  logic [DW-1:0] m_mem [NB][DEPTH];
  logic [DW-1:0] d_mem [NB][DEPTH];
  int            last_bank = -1;
  int            last_addr = -1;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_bank  = 0;
    m_ovf   = 0;
    m_full  = '0;
    e_write = '0;
    e_clken = '0;
    e_addr  = '0;
    e_data  = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented now.
  task automatic model_step();
    bit            acc;
    bit            wrap;
    int            nb;
    logic [NB-1:0] fa;
    mstate_t       ns;
    acc  = in_valid && (m_state == M_FILL);
    wrap = acc && (m_ptr == DEPTH - 1);
    nb   = (m_bank + 1) % NB;
    fa   = m_full & ~irq_ack;
    e_clken = '1;
    e_write = '0;
    if (acc) begin
      e_write[m_bank] = 1'b1;
      e_addr = m_ptr[AW-1:0];
      e_data = in_data;
    end
    if (!enable) ns = M_IDLE;
    else begin
      case (m_state)
        M_IDLE:  ns = m_full[m_bank] ? M_WAIT : M_FILL;
        M_FILL:  ns = (wrap && fa[nb]) ? M_WAIT : M_FILL;
        default: ns = m_full[m_bank] ? M_WAIT : M_FILL;
      endcase
    end
    if (m_state == M_WAIT && in_valid && m_ovf < 65535) m_ovf++;
    if (wrap) fa[m_bank] = 1'b1;
    m_full = fa;
    if (acc) m_ptr = (m_ptr + 1) % DEPTH;
    if (wrap) m_bank = nb;
    if (!enable) m_ptr = 0;
    m_state = ns;
  endtask

  // Compare process: check outputs on each falling edge, then step the model.
  initial begin
    forever begin
      @(negedge clk_clk);
      if (reset_reset) model_reset();
      chk("in_ready",       {31'd0, in_ready}, {31'd0, (m_state == M_FILL)});
      chk("mem_write",      32'(mem_write),      32'(e_write));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(e_write));
      chk("mem_clken",      32'(mem_clken),      32'(e_clken));
      chk("mem_byteenable", 32'(mem_byteenable), 32'h3);
      chk("irq",            32'(irq),            32'(m_full));
      chk("cur_bank",       32'(cur_bank),       32'(m_bank));
      chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
      if (e_write != '0 || reset_reset) begin
        chk("mem_address",   32'(mem_address),   32'(e_addr));
        chk("mem_writedata", 32'(mem_writedata), 32'(e_data));
      end
      if (!reset_reset) begin
        for (int b = 0; b < NB; b++) begin
          if (e_write[b]) m_mem[b][e_addr] = e_data;
          if (mem_write[b]) begin
            d_mem[b][mem_address] = mem_writedata;
            last_bank = b;
            last_addr = int'(mem_address);
            last_data = mem_writedata;
          end
        end
        model_step();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [NB-1:0] ack);
    in_valid = 1'b1;
    in_data  = d;
    irq_ack  = ack;
    cyc();
    in_valid = 1'b0;
    irq_ack  = '0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      cyc();
      k++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s: in_ready stayed 0, required 1 within 20 cycles", name);
    end
  endtask

  task automatic chk_last(input string name, input int b, input int a, input logic [DW-1:0] d);
    chk({name, "_bank"}, 32'(last_bank), 32'(b));
    chk({name, "_addr"}, 32'(last_addr), 32'(a));
    chk({name, "_data"}, 32'(last_data), 32'(d));
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        m_mem[b][a] = '0;
        d_mem[b][a] = '0;
      end

    repeat (3) @(posedge clk_clk);
    #2;
    chk("rst_irq",       32'(irq), 32'h0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'h0);
    chk("rst_mem_clken", 32'(mem_clken), 32'h0);
    chk("rst_ovf",       32'(overflow_count), 32'h0);

    // Basic fill of bank 0.
    reset_reset = 1'b0;
    enable      = 1'b1;
    cyc();
    chk("fill_ready", {31'd0, in_ready}, 32'h1);
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 2'b00);
    cyc();
    for (int i = 0; i < 8; i++) chk("bank0_word", 32'(d_mem[0][i]), 32'h0100 + 32'(i));
    chk("fill_irq",      32'(irq), 32'h1);
    chk("fill_cur_bank", 32'(cur_bank), 32'h1);

    // Ping-pong into bank 1, then drops while both banks are full.
    for (int i = 0; i < 8; i++) send(16'h0200 + 16'(i), 2'b00);
    chk("pp_irq",      32'(irq), 32'h3);
    chk("pp_in_ready", {31'd0, in_ready}, 32'h0);
    for (int i = 0; i < 5; i++) send(16'hFF00, 2'b00);
    chk("pp_ovf",       32'(overflow_count), 32'd5);
    chk("pp_model_ovf", 32'(m_ovf), 32'd5);

    // Recovery after draining bank 0.
    irq_ack = 2'b01;
    cyc();
    irq_ack = 2'b00;
    chk("rec_irq",    32'(irq), 32'h2);
    chk("rec_ready0", {31'd0, in_ready}, 32'h0);
    cyc();
    chk("rec_ready1", {31'd0, in_ready}, 32'h1);
    send(16'hBEEF, 2'b00);
    cyc();
    chk_last("rec", 0, 0, 16'hBEEF);

    // Collision: acknowledge bank 0 in the cycle it fills.
    for (int i = 1; i < 8; i++) send(16'h0300 + 16'(i), (i == 7) ? 2'b01 : 2'b00);
    chk("col_irq",      32'(irq), 32'h3);
    chk("col_in_ready", {31'd0, in_ready}, 32'h0);

    // Abort: partial bank 1 discarded, refill restarts at address 0.
    irq_ack = 2'b10;
    cyc();
    irq_ack = 2'b00;
    wait_ready("abort_resume");
    for (int i = 0; i < 3; i++) send(16'h0400 + 16'(i), 2'b00);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    wait_ready("abort_reenable");
    send(16'h5A5A, 2'b00);
    cyc();
    chk_last("abort", 1, 0, 16'h5A5A);
    chk("abort_irq", 32'(irq), 32'h1);

    // Reset mid-fill with a sample pending.
    for (int i = 0; i < 4; i++) send(16'h0600 + 16'(i), 2'b00);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    #1;
    reset_reset = 1'b1;
    #1;
    chk("mrst_write",    32'(mem_write), 32'h0);
    chk("mrst_cs",       32'(mem_chipselect), 32'h0);
    chk("mrst_irq",      32'(irq), 32'h0);
    chk("mrst_ready",    {31'd0, in_ready}, 32'h0);
    chk("mrst_addr",     32'(mem_address), 32'h0);
    chk("mrst_data",     32'(mem_writedata), 32'h0);
    chk("mrst_cur_bank", 32'(cur_bank), 32'h0);
    chk("mrst_ovf",      32'(overflow_count), 32'h0);
    in_valid = 1'b0;
    cyc();
    reset_reset = 1'b0;
    wait_ready("mrst_resume");
    send(16'h1234, 2'b00);
    cyc();
    chk_last("mrst", 0, 0, 16'h1234);
    chk("mrst_ovf_after", 32'(overflow_count), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 99) < 97);
      in_valid   = ($urandom_range(0, 99) < 75);
      in_data    = 16'($urandom);
      irq_ack[0] = ($urandom_range(0, 99) < 6);
      irq_ack[1] = ($urandom_range(0, 99) < 6);
      cyc();
    end
    in_valid = 1'b0;
    irq_ack  = '0;
    cyc();
    cyc();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++)
        chk("mem_image", 32'(d_mem[b][a]), 32'(m_mem[b][a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qkd_bank_writer.md
QKD_BANK_WRITER -- requirements
Module: qkd_bank_writer

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 2, giving the number of on-chip memory banks, legal range 2..8.
REQ-002 The block SHALL have parameter ADDR_W, default 11, giving the bank address width, so depth is 2^ADDR_W words, legal range 2..16.
REQ-003 The block SHALL have parameter DATA_W, default 16, giving the word width, which SHALL be a multiple of 8.
REQ-004 The block SHALL have port clk_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: capture enable.
REQ-007 The block SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_ready (output, 1): the sample stream.
REQ-008 The block SHALL have port mem_address, output, ADDR_W: the shared write address to all banks.
REQ-009 The block SHALL have port mem_writedata, output, DATA_W: the shared write data to all banks.
REQ-010 The block SHALL have port mem_byteenable, output, DATA_W/8: the shared byte enables.
REQ-011 The block SHALL have ports mem_clken, mem_chipselect and mem_write, each output, NUM_BANKS: per-bank memory slave strobes.
REQ-012 The block SHALL have port irq, output, NUM_BANKS: a level per bank, high while that bank is full; it routes to the HPS f2h irq.
REQ-013 The block SHALL have port irq_ack, input, NUM_BANKS: a one-cycle pulse per bank from software, meaning "bank drained".
REQ-014 The block SHALL have port cur_bank, output, 3 bits: the index of the bank currently being filled.
REQ-015 The block SHALL have port overflow_count, output, 16 bits: the number of samples dropped.

Function
REQ-016 The block SHALL implement the states IDLE, FILL and WAIT_FREE.
REQ-017 in_ready SHALL be 1 only in FILL, and a sample SHALL be accepted when in_valid and in_ready are both 1.
REQ-018 For an accepted sample, in the next cycle mem_write[cur_bank] and mem_chipselect[cur_bank] SHALL be 1, mem_address SHALL equal wr_ptr, and mem_writedata SHALL equal in_data (one-cycle latency, registered outputs).
REQ-019 When no sample is accepted, all mem_write and mem_chipselect bits SHALL be 0 in the next cycle.
REQ-020 mem_byteenable SHALL be all ones, and mem_clken SHALL be all ones in every cycle after reset release.
REQ-021 wr_ptr SHALL increment by 1 per accepted sample.
REQ-022 On the sample accepted at wr_ptr = 2^ADDR_W-1:
- full[cur_bank] and irq[cur_bank] SHALL be set;
- wr_ptr SHALL wrap to 0;
- cur_bank SHALL advance to (cur_bank+1) mod NUM_BANKS.
REQ-023 Transition IDLE -> FILL SHALL occur when enable=1 and full[cur_bank]=0; when enable=1 and full[cur_bank]=1 the transition SHALL be IDLE -> WAIT_FREE.
REQ-024 Transition FILL -> WAIT_FREE SHALL occur in the same cycle the bank advance targets a bank whose full bit is 1, where that full bit is evaluated after this cycle's irq_ack.
REQ-025 Transition WAIT_FREE -> FILL SHALL occur the cycle after full[cur_bank] clears.
REQ-026 In WAIT_FREE, each cycle with in_valid=1 SHALL increment overflow_count, saturating at 16'hFFFF.
REQ-027 irq_ack[i] SHALL clear full[i] and irq[i] in the next cycle.
REQ-028 If the set of full[i] and irq_ack[i] occur in the same cycle, set SHALL win.
REQ-029 irq_ack to a bank that is not full SHALL have no effect.
REQ-030 On enable=0 in any state, the block SHALL go to IDLE next cycle and wr_ptr SHALL reset to 0, discarding the partial bank; cur_bank, full, irq and overflow_count SHALL be retained.
REQ-031 A sample accepted in the same cycle enable falls SHALL still be written.

Reset
REQ-032 While reset_reset=1, asynchronously:
- state SHALL be IDLE, and wr_ptr, cur_bank, full and overflow_count SHALL be 0;
- irq, mem_write, mem_chipselect, mem_clken, mem_address and mem_writedata SHALL be 0, and in_ready SHALL be 0.
REQ-033 Reset asserted mid-fill SHALL abandon any pending write with no write strobe.
REQ-034 The block SHALL leave IDLE no earlier than the first rising edge after reset deasserts.

Verification (NUM_BANKS=2, ADDR_W=3, DATA_W=16)
REQ-035 Basic fill: enable=1, stream 8 samples 0x0100..0x0107 -> bank0 addresses 0..7 get those values at 1-cycle latency; irq=2'b01; cur_bank=1.
REQ-036 Ping-pong: 16 samples with no ack -> irq=2'b11, state WAIT_FREE, in_ready=0; 5 further in_valid cycles -> overflow_count=5.
REQ-037 Recovery: after REQ-036, irq_ack=2'b01 -> irq=2'b10 next cycle, in_ready=1 one cycle later, next sample written to bank0 address 0.
REQ-038 Collision: irq_ack[0] pulsed in the same cycle bank0 fills -> irq[0] remains 1.
REQ-039 Abort: enable=0 after 3 samples, then enable=1 -> next sample written to address 0 of the same bank, irq unchanged.
REQ-040 Reset mid-fill: reset_reset pulsed after 4 samples -> all outputs 0 immediately; after release, the first sample goes to bank0 address 0 and overflow_count=0.
